// File: rtl/axi_rdata_fifo_rsp_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the read responder and its requester.
interface axi_rdata_fifo_rsp_if #(
    parameter int DATA_W = 32
);
    logic              ARVALID;
    logic              ARREADY;
    logic [31:0]       ARADDR;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    modport master (
        output ARVALID, ARADDR, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_rdata_fifo_rsp.sv
// AXI4-Lite read responder: holds the AR address for the decoder, waits out its latency,
// then answers with a popped read-FIFO word, write-FIFO status, or an ID word.
module axi_rdata_fifo_rsp #(
    parameter int                DATA_W   = 32,
    parameter int                CNT_W    = 8,
    parameter int                EN_LAT   = 2,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'h4D4C_4453
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_rdata_fifo_rsp_if.slave axi,
    output logic [31:0]       araddr_hold,
    input  logic              rrr_en_w_fifo,
    input  logic              rrr_en_r_fifo,
    input  logic              r_fifo_empty,
    output logic              r_fifo_rd_en,
    input  logic [DATA_W-1:0] r_fifo_dout,
    input  logic [CNT_W-1:0]  w_fifo_count,
    input  logic              w_fifo_full
);
    localparam int         DLY_W     = $clog2(EN_LAT + 2);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLV  = 2'b10;

    typedef enum logic [2:0] {IDLE, DEC, POP, CAP, RESP} state_t;

    state_t            state, state_n;
    logic [DLY_W-1:0]  dly_cnt, dly_cnt_n;
    logic              arready, arready_n;
    logic              rvalid, rvalid_n;
    logic [DATA_W-1:0] rdata, rdata_n;
    logic [1:0]        rresp, rresp_n;
    logic              rd_en_n;
    logic [31:0]       hold_n;

    // NOTE: every registered output shares one reset so a mid-transaction reset drops the bus cleanly.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            dly_cnt      <= '0;
            arready      <= 1'b0;
            rvalid       <= 1'b0;
            rdata        <= '0;
            rresp        <= RESP_OKAY;
            r_fifo_rd_en <= 1'b0;
            araddr_hold  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
            state        <= state_n;
            dly_cnt      <= dly_cnt_n;
            arready      <= arready_n;
            rvalid       <= rvalid_n;
            rdata        <= rdata_n;
            rresp        <= rresp_n;
            r_fifo_rd_en <= rd_en_n;
            araddr_hold  <= hold_n;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first so no path through the case infers a latch.
        state_n   = state;
        dly_cnt_n = dly_cnt;
        arready_n = arready;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        rd_en_n   = 1'b0;
        hold_n    = araddr_hold;

        unique case (state)
            IDLE: begin
                arready_n = 1'b1;
                if (axi.ARVALID && arready) begin
                    hold_n    = axi.ARADDR;
                    arready_n = 1'b0;
                    dly_cnt_n = '0;
                    state_n   = DEC;
                end
            end
            DEC: begin
                if (dly_cnt == DLY_W'(EN_LAT)) begin
                    // Enables are only trusted once the decoder has seen araddr_hold for EN_LAT cycles.
                    state_n  = RESP;
                    rvalid_n = 1'b1;
                    unique case ({rrr_en_r_fifo, rrr_en_w_fifo})
                        2'b10: begin
                            if (r_fifo_empty) begin
                                rdata_n = '0;
                                rresp_n = RESP_SLV;
                            end else begin
                                rvalid_n = 1'b0;
                                rd_en_n  = 1'b1;
                                state_n  = POP;
                            end
                        end
                        2'b01: begin
                            rdata_n = {w_fifo_full, (DATA_W-1)'(w_fifo_count)};
                            rresp_n = RESP_OKAY;
                        end
                        2'b00: begin
                            rdata_n = ID_VALUE;
                            rresp_n = RESP_OKAY;
                        end
                        default: begin
                            rdata_n = '0;
                            rresp_n = RESP_SLV;
                        end
                    endcase
                end else begin
                    dly_cnt_n = dly_cnt + 1'b1;
                end
            end
            POP: state_n = CAP;
            CAP: begin
                rdata_n  = r_fifo_dout;
                rresp_n  = RESP_OKAY;
                rvalid_n = 1'b1;
                state_n  = RESP;
            end
            RESP: begin
                if (axi.RREADY) begin
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid;
    assign axi.RDATA   = rdata;
    assign axi.RRESP   = rresp;
endmodule

// File: tb/tb_axi_rdata_fifo_rsp.sv
// Directed bench for axi_rdata_fifo_rsp with a 2-stage address decoder model and a one-word read FIFO.
module tb_axi_rdata_fifo_rsp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_w, en_r;
    logic        r_empty;
    logic        rd_en;
    logic [31:0] r_dout;
    logic [31:0] fifo_word;
    logic [7:0]  w_count;
    logic        w_full;
    logic [31:0] hold;
    logic [1:0]  dec_s1, dec_s2;

    int vectors    = 0;
    int miscompares = 0;
    int pops       = 0;

    axi_rdata_fifo_rsp_if #(.DATA_W(32)) axi ();

    axi_rdata_fifo_rsp dut (
        .ACLK          (clk),
        .ARESETn       (rst_n),
        .axi           (axi.slave),
        .araddr_hold   (hold),
        .rrr_en_w_fifo (en_w),
        .rrr_en_r_fifo (en_r),
        .r_fifo_empty  (r_empty),
        .r_fifo_rd_en  (rd_en),
        .r_fifo_dout   (r_dout),
        .w_fifo_count  (w_count),
        .w_fifo_full   (w_full)
    );

    always #5 clk = ~clk;

    // Decoder model: 0x10 -> write-FIFO status, 0x11 -> read-FIFO data, 0x12 -> both (illegal).
    always @(posedge clk) begin
        dec_s1 <= {(hold == 32'h11) || (hold == 32'h12), (hold == 32'h10) || (hold == 32'h12)};
        dec_s2 <= dec_s1;
    end
    assign en_r = dec_s2[1];
    assign en_w = dec_s2[0];

    always @(posedge clk) if (rd_en) r_dout <= fifo_word;
    always @(posedge rd_en) pops++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_arready"}, 64'(axi.ARREADY), 64'd0);
        check({tag, "_rvalid"},  64'(axi.RVALID),  64'd0);
        check({tag, "_rdata"},   64'(axi.RDATA),   64'd0);
        check({tag, "_rresp"},   64'(axi.RRESP),   64'd0);
        check({tag, "_rd_en"},   64'(rd_en),       64'd0);
        check({tag, "_hold"},    64'(hold),        64'd0);
    endtask

    // Handshake on AR, then scramble ARADDR to show it is not re-sampled.
    task automatic start_ar(input logic [31:0] addr);
        int k = 0;
        while (!axi.ARREADY && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) check("arready_wait", 64'(axi.ARREADY), 64'd1);
        axi.ARVALID = 1'b1;
        axi.ARADDR  = addr;
        tick();
        axi.ARVALID = 1'b0;
        axi.ARADDR  = 32'hFFFF_FFF0;
    endtask

    // Full read; stall cycles hold RREADY low after RVALID rises while checking stability.
    task automatic do_read(input logic [31:0] addr, input int stall, input logic [31:0] exp_data,
                           output int lat, output logic [31:0] data, output logic [1:0] resp);
        axi.RREADY = (stall == 0);
        start_ar(addr);
        lat = 0;
        while (!axi.RVALID && lat < 20) begin
            tick();
            lat++;
        end
        data = axi.RDATA;
        resp = axi.RRESP;
        for (int i = 0; i < stall; i++) begin
            check("stall_rdata",   64'(axi.RDATA),   64'(exp_data));
            check("stall_rvalid",  64'(axi.RVALID),  64'd1);
            check("stall_arready", 64'(axi.ARREADY), 64'd0);
            tick();
        end
        axi.RREADY = 1'b1;
        tick();
        check("post_rvalid",  64'(axi.RVALID),  64'd0);
        check("post_arready", 64'(axi.ARREADY), 64'd1);
    endtask

    initial begin
        int          lat;
        int          p0;
        logic [31:0] data;
        logic [1:0]  resp;

        axi.ARVALID = 1'b0;
        axi.ARADDR  = '0;
        axi.RREADY  = 1'b1;
        r_empty     = 1'b1;
        fifo_word   = 32'hDEAD_BEEF;
        w_count     = 8'd37;
        w_full      = 1'b0;

        // Reset and release
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("release_arready", 64'(axi.ARREADY), 64'd1);
        check("release_rvalid",  64'(axi.RVALID),  64'd0);
        check("release_pops",    64'(pops),        64'd0);

        // Write-FIFO status
        p0 = pops;
        do_read(32'h10, 0, 32'h25, lat, data, resp);
        check("status_lat",  64'(lat),  64'd3);
        check("status_data", 64'(data), 64'h25);
        check("status_resp", 64'(resp), 64'd0);
        check("status_pops", 64'(pops - p0), 64'd0);
        check("status_hold", 64'(hold), 64'h10);

        // Read-FIFO pop
        r_empty = 1'b0;
        p0 = pops;
        do_read(32'h11, 0, 32'hDEAD_BEEF, lat, data, resp);
        check("pop_lat",  64'(lat),  64'd5);
        check("pop_data", 64'(data), 64'hDEAD_BEEF);
        check("pop_resp", 64'(resp), 64'd0);
        check("pop_pops", 64'(pops - p0), 64'd1);

        // Read-FIFO empty -> SLVERR
        r_empty = 1'b1;
        p0 = pops;
        do_read(32'h11, 0, 32'h0, lat, data, resp);
        check("empty_lat",  64'(lat),  64'd3);
        check("empty_data", 64'(data), 64'h0);
        check("empty_resp", 64'(resp), 64'd2);
        check("empty_pops", 64'(pops - p0), 64'd0);

        // ID word
        do_read(32'h0, 0, 32'h4D4C_4453, lat, data, resp);
        check("id_lat",  64'(lat),  64'd3);
        check("id_data", 64'(data), 64'h4D4C_4453);
        check("id_resp", 64'(resp), 64'd0);

        // Both enables -> SLVERR, no pop even with data present
        r_empty = 1'b0;
        p0 = pops;
        do_read(32'h12, 0, 32'h0, lat, data, resp);
        check("illegal_data", 64'(data), 64'h0);
        check("illegal_resp", 64'(resp), 64'd2);
        check("illegal_pops", 64'(pops - p0), 64'd0);

        // Status with full and stalled RREADY
        w_count = 8'd255;
        w_full  = 1'b1;
        do_read(32'h10, 7, 32'h8000_00FF, lat, data, resp);
        check("stall_lat",  64'(lat),  64'd3);
        check("stall_data", 64'(data), 64'h8000_00FF);
        check("stall_resp", 64'(resp), 64'd0);

        // Reset during POP
        fifo_word = 32'h1234_5678;
        p0 = pops;
        start_ar(32'h11);
        lat = 0;
        while (!rd_en && lat < 10) begin
            tick();
            lat++;
        end
        check("rstpop_reached", 64'(rd_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstpop");
        repeat (3) tick();
        check("rstpop_pops", 64'(pops - p0), 64'd1);
        rst_n = 1'b1;
        tick();
        p0 = pops;
        do_read(32'h11, 0, 32'h1234_5678, lat, data, resp);
        check("after_rstpop_lat",  64'(lat),  64'd5);
        check("after_rstpop_data", 64'(data), 64'h1234_5678);
        check("after_rstpop_pops", 64'(pops - p0), 64'd1);

        // Reset during RESP
        axi.RREADY = 1'b0;
        start_ar(32'h10);
        lat = 0;
        while (!axi.RVALID && lat < 20) begin
            tick();
            lat++;
        end
        check("rstresp_rvalid", 64'(axi.RVALID), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstresp");
        tick();
        rst_n = 1'b1;
        axi.RREADY = 1'b1;
        tick();
        do_read(32'h0, 0, 32'h4D4C_4453, lat, data, resp);
        check("after_rstresp_lat",  64'(lat),  64'd3);
        check("after_rstresp_data", 64'(data), 64'h4D4C_4453);
        check("after_rstresp_resp", 64'(resp), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_rdata_fifo_rsp.md
Name: axi_rdata_fifo_rsp

Overview:
AXI4-Lite read-channel responder that sits directly downstream of the read-address decoder in the sampler AXI wrapper. It accepts the AR handshake and holds the accepted address on araddr_hold, which the top level wires back into the decoder's ARADDR input. It then consumes the decoder's registered rrr_en_w_fifo / rrr_en_r_fifo enables and builds the R-channel beat. For the read-FIFO target it pops one word; for the write-FIFO target it returns status; for idle it returns an ID word.

Parameters:
DATA_W, 32, RDATA and r_fifo_dout width
CNT_W, 8, width of w_fifo_count
EN_LAT, 2, decoder latency in cycles from araddr_hold change to valid enables
ID_VALUE, 32'h4D4C_4453, RDATA returned when neither enable is set

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
ARVALID  in  1  AR channel valid
ARREADY  out  1  AR channel ready
ARADDR  in  32  read address
araddr_hold  out  32  accepted address, held until R handshake; drives decoder ARADDR
rrr_en_w_fifo  in  1  decoder enable: write-FIFO status target
rrr_en_r_fifo  in  1  decoder enable: read-FIFO data target
r_fifo_empty  in  1  read FIFO empty flag
r_fifo_rd_en  out  1  one-cycle pop strobe
r_fifo_dout  in  DATA_W  read FIFO data, valid one cycle after r_fifo_rd_en
w_fifo_count  in  CNT_W  write FIFO occupancy
w_fifo_full  in  1  write FIFO full flag
RVALID  out  1  R channel valid
RREADY  in  1  R channel ready
RDATA  out  DATA_W  read data
RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Reset (asynchronous, any time including mid-transaction):
  - ARREADY=0, RVALID=0, RDATA=0, RRESP=0, r_fifo_rd_en=0, araddr_hold=0.
  - FSM goes to IDLE and the delay counter clears.
  - No pop is issued.
- All outputs are registered.
- FSM states: IDLE, DEC, POP, CAP, RESP.
- IDLE:
  - ARREADY=1, starting from the first edge after reset release.
  - At the edge where ARVALID&&ARREADY: araddr_hold<=ARADDR, ARREADY<=0, go to DEC, counter<=0.
- DEC:
  - Lasts EN_LAT+1 cycles (3 by default). The enables are sampled at the edge that ends DEC.
  - Sample results:
    - r=1, w=0, r_fifo_empty=0: go to POP.
    - r=1, w=0, empty=1: RDATA<=0, RRESP<=SLVERR, go to RESP. No pop.
    - w=1, r=0: RDATA<={w_fifo_full, zero-extend w_fifo_count}, with full at bit DATA_W-1. RRESP<=OKAY. Go to RESP.
    - Both 0: RDATA<=ID_VALUE, RRESP<=OKAY, go to RESP.
    - Both 1 (illegal): RDATA<=0, RRESP<=SLVERR, go to RESP. No pop.
- POP:
  - Exactly one cycle with r_fifo_rd_en=1, then CAP.
  - r_fifo_rd_en is high only in POP, exactly once per transaction.
- CAP:
  - One cycle. At its end: RDATA<=r_fifo_dout, RRESP<=OKAY, go to RESP.
- RESP:
  - RVALID=1. RDATA/RRESP are stable while RVALID&&!RREADY, held for any number of stall cycles.
  - At the edge where RVALID&&RREADY: RVALID<=0, ARREADY<=1, go to IDLE.
- araddr_hold changes only on the AR handshake.
- Latency, counting cycles from the AR handshake edge to the RVALID rise:
  - EN_LAT+1 (3) for status/ID/error responses.
  - EN_LAT+3 (5) for a read-FIFO pop.
- Back-to-back reads: at least one cycle in IDLE between the R handshake and the next AR handshake. There are no outstanding transactions.
- ARVALID asserted outside IDLE is ignored (ARREADY=0).
- Changes on ARADDR after the handshake have no effect.
- Changes on r_fifo_empty after the DEC sample have no effect; the POP still occurs.

Test Plan:
- Reset, then release -> ARREADY=1 one edge later; RVALID=0; r_fifo_rd_en never pulses.
- ARADDR=0x10 with w_fifo_count=8'd37 and w_fifo_full=0, RREADY=1 -> RVALID rises 3 cycles after handshake; RDATA=0x0000_0025, RRESP=00; no pop.
- ARADDR=0x11 with FIFO holding 0xDEAD_BEEF, empty=0 -> one r_fifo_rd_en pulse; RVALID 5 cycles after handshake; RDATA=0xDEAD_BEEF, RRESP=00.
- ARADDR=0x11 with empty=1 -> RDATA=0, RRESP=2'b10, no pop; ARADDR=0x0 -> RDATA=0x4D4C_4453, OKAY.
- RREADY held low 7 cycles during a w_fifo status read with w_fifo_full=1 and count=255 -> RDATA=0x8000_00FF stable throughout; ARREADY=0 until the handshake, then 1.
- ARESETn asserted during POP and during RESP -> all outputs 0 immediately, no second pop; a fresh read after release completes normally.
